// File: rtl/bvp_shr_pkg.sv
// Shared sizing and tap-clamp helpers for the variable-delay shift line.
package bvp_shr_pkg;

  // Width of a port that carries a delay value in the range 0..depth.
  function automatic int delay_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of the stage index 0..depth-1 (depth is at least 2).
  function automatic int tap_width(input int depth);
    return $clog2(depth);
  endfunction

  // Effective delay: zero behaves as one, values past the line length pin to its end.
  function automatic int clamp_delay(input int dly, input int depth);
    int d;
    if (dly == 0) begin
      d = 1;
    end else if (dly > depth) begin
      d = depth;
    end else begin
      d = dly;
    end
    return d;
  endfunction

endpackage

// File: rtl/var_delay_lane.sv
// One data lane of the delay line: a reset-free shift register with a
// runtime tap mux. Validity is tracked once, outside the lanes.
module var_delay_lane
  import bvp_shr_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int DATA_BITS = 8,
  localparam int TW       = tap_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] din,
  input  logic [TW-1:0]        tap,
  output logic [DATA_BITS-1:0] dout
);

  logic [DATA_BITS-1:0] stage_r [DEPTH];

  // Advance the lane by one stage on every accepted shift; data carries no reset.
  always_ff @(posedge clk) begin
    if (shift) begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign dout = stage_r[tap];

endmodule

// File: rtl/var_delay_shreg.sv
// Multi-lane variable-delay shift register. A single valid line, occupancy
// counter and tap decoder are shared by CHANNELS reset-free data lanes.
module var_delay_shreg
  import bvp_shr_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 1,
  localparam int DW       = delay_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clken,
  input  logic                          flush,
  input  logic [DW-1:0]                 delay,
  input  logic                          si_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] si_data,
  output logic                          so_valid,
  output logic [CHANNELS*DATA_BITS-1:0] so_data,
  output logic [DW-1:0]                 occ,
  output logic                          primed
);

  localparam int            TW      = tap_width(DEPTH);
  localparam logic [DW-1:0] OCC_MAX = DW'(DEPTH);

  logic [DEPTH-1:0] valid_r;
  logic [DW-1:0]    occ_r;
  logic [DW-1:0]    eff_s;
  logic [TW-1:0]    tap_s;
  logic             shift_s;

  // Flush wins over an enable, so the sample offered on a flush edge is dropped.
  assign shift_s = clken & ~flush;

  // Clamp the requested delay and turn it into a stage index (delay d taps stage d-1).
  always_comb begin
    eff_s = DW'(clamp_delay(int'(delay), DEPTH));
    tap_s = TW'(eff_s - DW'(1));
  end

  // Valid line and saturating occupancy; only these carry reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      occ_r   <= '0;
    end else if (flush) begin
      valid_r <= '0;
      occ_r   <= '0;
    end else if (clken) begin
      valid_r <= {valid_r[DEPTH-2:0], si_valid};
      if (occ_r != OCC_MAX) begin
        occ_r <= occ_r + DW'(1);
      end
    end
  end

  assign so_valid = valid_r[tap_s];
  assign occ      = occ_r;
  assign primed   = (occ_r >= eff_s);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    var_delay_lane #(
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS)
    ) u_lane (
      .clk   (clk),
      .shift (shift_s),
      .din   (si_data[c*DATA_BITS +: DATA_BITS]),
      .tap   (tap_s),
      .dout  (so_data[c*DATA_BITS +: DATA_BITS])
    );
  end

endmodule

// File: doc/var_delay_shreg.md
VAR_DELAY_SHREG -- requirements
Module: var_delay_shreg

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of shift stages; legal range 2..256.
REQ-002 SHALL have parameter DATA_BITS, default 8: bits per channel sample.
REQ-003 SHALL have parameter CHANNELS, default 1: number of parallel lanes sharing one shift control; legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port clken, input, 1 bit: shift enable; the line advances only on edges where clken=1.
REQ-007 SHALL have port flush, input, 1 bit: synchronous invalidate of all stages.
REQ-008 SHALL have port delay, input, DW=$clog2(DEPTH+1) bits: runtime tap select, in enabled cycles.
REQ-009 SHALL have port si_valid, input, 1 bit: qualifies si_data.
REQ-010 SHALL have port si_data, input, CHANNELS*DATA_BITS bits: lane c at [c*DATA_BITS +: DATA_BITS].
REQ-011 SHALL have port so_valid, output, 1 bit: valid bit at the selected tap.
REQ-012 SHALL have port so_data, output, CHANNELS*DATA_BITS bits: data at the selected tap, same lane packing.
REQ-013 SHALL have port occ, output, DW bits: enabled shifts since reset/flush, saturating at DEPTH.
REQ-014 SHALL have port primed, output, 1 bit: 1 when occ >= effective delay.

Function
REQ-015 Stage 0 SHALL be the newest; on an enabled edge, stage 0 <= {si_valid, si_data} and stage k <= stage k-1 for k = 1..DEPTH-1.
REQ-016 Effective delay d SHALL be: delay=0 -> 1; delay>DEPTH -> DEPTH; otherwise delay.
REQ-017 so_data and so_valid SHALL be a combinational mux of stage d-1 registers; no input-to-output combinational path.
REQ-018 A sample accepted on enabled edge n SHALL appear on so_* after enabled edge n+d-1, i.e. exactly d enabled edges including the accepting edge.
REQ-019 When clken=0, all stages, occ and outputs SHALL hold; disabled cycles SHALL not count toward latency.
REQ-020 A change of delay SHALL retarget the tap in the same cycle; no data SHALL be moved or dropped, and so_valid reflects the new tap's valid bit.
REQ-021 flush=1 on an edge SHALL clear every stage valid bit and set occ=0, regardless of clken; si on that edge SHALL be discarded.
REQ-022 Data bits SHALL not be cleared by flush or reset; only valid bits and occ carry reset/flush.
REQ-023 occ SHALL increment by 1 per enabled non-flush edge and saturate at DEPTH without wrap.
REQ-024 primed SHALL be computed combinationally from occ and d, and SHALL follow delay changes in the same cycle.
REQ-025 A stage with si_valid=0 SHALL propagate as a bubble (valid=0) while still advancing occ.

Reset
REQ-026 While rst_n=0: all stage valid bits = 0, occ = 0, so_valid = 0, primed = 0; so_data undefined.
REQ-027 Reset assertion SHALL take effect asynchronously; deassertion is synchronised externally; the first enabled edge after release SHALL be accepted as for REQ-015.
REQ-028 Reset mid-stream SHALL discard all in-flight samples; no stale so_valid=1 after release until a new sample reaches the tap.

Structure
REQ-029 Package bvp_shr_pkg SHALL hold the delay-width function (clog2(DEPTH+1)) and the delay clamp function used by REQ-016.
REQ-030 A sub-module var_delay_lane (one DATA_BITS lane, no reset) SHALL be instantiated CHANNELS times; valid shift register, occ and tap decode live once in the top.

Verification
REQ-031 DEPTH=32, CH=2, delay=5, clken=1, push 0x11/0x22..0x88 valid -> so_valid first 1 five edges after first push; so_data=0x11/0x22 etc., one per cycle.
REQ-032 delay=5, clken toggled 1,0,1,0 -> 0x11 emerges after 5 enabled edges (10 clocks); outputs hold in disabled cycles.
REQ-033 Stream to occ=10 with delay=4, then set delay=8 -> so_* shows stage 7 same cycle, primed stays 1; set delay=12 -> primed=0 until occ=12.
REQ-034 delay=0 -> behaves as delay=1; delay=40 on DEPTH=32 -> behaves as 32; occ saturates at 32 after 50 shifts.
REQ-035 Stream at delay=3, assert flush with clken=0 -> next cycle so_valid=0, occ=0, primed=0; new sample appears 3 enabled edges later.
REQ-036 Assert rst_n=0 asynchronously mid-stream (between edges) -> so_valid and primed drop immediately; after release no valid output until a fresh sample traverses d stages.
